// File: rtl/button_pkg.sv
// button_pkg: shared debounce state type and default timing constants.
package button_pkg;
  typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;
  localparam int DB_SYNC_STAGES = 2;
  localparam int DB_STABLE_CYCLES = 4;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit synchronizer plus stability filter for a single key.
module debounce_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES = DB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic busy
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  db_state_t state;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  // any return of s to the clean level abandons the candidate and clears the count
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      cnt <= '0;
      state <= DB_STABLE;
      clean <= 1'b0;
      busy <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (s == clean) begin
        state <= DB_STABLE;
        busy <= 1'b0;
        cnt <= '0;
      end else if (state == DB_STABLE) begin
        state <= DB_COUNTING;
        busy <= 1'b1;
        cnt <= CW'(1);
      end else if (cnt == LAST) begin
        clean <= s;
        state <= DB_STABLE;
        busy <= 1'b0;
        cnt <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: N independent synchronize-and-debounce key channels.
module button_debouncer
  import button_pkg::*;
#(
  parameter int N = 4,
  parameter int SYNC_STAGES = DB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
  parameter bit INVERT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] raw,
  output logic [N-1:0] clean,
  output logic [N-1:0] busy
);
  logic [N-1:0] keys;
  assign keys = raw ^ {N{INVERT}};
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(keys[i]),
      .clean(clean[i]),
      .busy(busy[i])
    );
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed and random checks of both polarities against a sliding-window model.
module tb_button_debouncer;
  localparam int N = 4;
  localparam int SS = 2;
  localparam int SC = 4;
  logic clk, reset;
  logic [N-1:0] raw, raw_n, clean, busy, clean_i, busy_i;
  int passed = 0, total = 0;
  bit armed = 0;
  assign raw_n = ~raw;
  button_debouncer #(.N(N), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .raw(raw), .clean(clean), .busy(busy));
  button_debouncer #(.N(N), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .raw(raw_n), .clean(clean_i), .busy(busy_i));
  initial clk = 0;
  always #5 clk = ~clk;
  // model: s is raw delayed SS edges; clean flips when the last SC s-samples all differ from it
  logic [N-1:0] hist[SS] = '{default: '0};
  logic [N-1:0] win[SC] = '{default: '0};
  logic [N-1:0] mclean = '0, mbusy = '0;
  always @(posedge clk or negedge reset) begin
    logic [N-1:0] s;
    bit all;
    if (!reset) begin
      for (int i = 0; i < SS; i++) hist[i] = '0;
      for (int i = 0; i < SC; i++) win[i] = '0;
      mclean = '0;
      mbusy = '0;
    end else begin
      s = hist[SS-1];
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw;
      for (int i = SC - 1; i > 0; i--) win[i] = win[i-1];
      win[0] = s;
      for (int c = 0; c < N; c++) begin
        all = 1;
        for (int i = 0; i < SC; i++) if (win[i][c] == mclean[c]) all = 0;
        if (all) mclean[c] = s[c];
        mbusy[c] = !all && (s[c] != mclean[c]);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic mchk();
    if (armed) begin
      chk("model_clean", clean, mclean);
      chk("model_busy", busy, mbusy);
      chk("model_clean_inv", clean_i, mclean);
      chk("model_busy_inv", busy_i, mbusy);
    end
  endtask
  task automatic cyc(input logic [N-1:0] r);
    raw = r;
    @(negedge clk);
    mchk();
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_clean"}, clean, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_clean_inv"}, clean_i, 0);
    chk({tag, "_busy_inv"}, busy_i, 0);
  endtask
  initial begin
    logic [N-1:0] r;
    int rate;
    reset = 1;
    raw = '0;
    repeat (3) @(negedge clk);
    #2 raw = 4'hF;
    reset = 0;
    #1 zero_chk("rst_async");
    armed = 1;
    repeat (2) begin
      @(negedge clk);
      mchk();
      zero_chk("rst_hold");
    end
    reset = 1;
    for (int e = 1; e <= 8; e++) begin
      cyc(4'h1);
      chk("s2_busy0", busy[0], 32'(e >= 3 && e <= 5));
      chk("s2_clean0", clean[0], 32'(e >= 6));
      chk("s2_busy0_inv", busy_i[0], 32'(e >= 3 && e <= 5));
      chk("s2_clean0_inv", clean_i[0], 32'(e >= 6));
      chk("s2_clean_hi", clean[3:1], 0);
    end
    for (int e = 1; e <= 8; e++) begin
      cyc(e <= 2 ? 4'h3 : 4'h1);
      chk("s3_clean1", clean[1], 0);
      chk("s3_busy1", busy[1], 32'(e == 3 || e == 4));
    end
    for (int e = 1; e <= 12; e++) begin
      cyc({1'b0, (e == 2 || e == 4) ? 1'b0 : 1'b1, 2'b01});
      chk("s4_clean2", clean[2], 32'(e >= 10));
    end
    for (int e = 1; e <= 8; e++) begin
      cyc(4'hC);
      chk("s5_clean0", clean[0], 32'(e < 6));
      chk("s5_clean3", clean[3], 32'(e >= 6));
    end
    for (int e = 1; e <= 4; e++) cyc(4'hE);
    chk("s6_busy1_mid", busy[1], 1);
    #2 reset = 0;
    #1 zero_chk("s6_rst_async");
    @(negedge clk);
    mchk();
    reset = 1;
    for (int e = 1; e <= 8; e++) begin
      cyc(4'hE);
      chk("s6_clean", clean, e >= 6 ? 32'hE : 0);
      chk("s6_clean_inv", clean_i, e >= 6 ? 32'hE : 0);
    end
    r = raw;
    rate = 4;
    for (int k = 0; k < 600; k++) begin
      if (k % 32 == 0) rate = $urandom_range(1, 0) ? 1 : 12;
      for (int c = 0; c < N; c++) if ($urandom_range(rate, 0) == 0) r[c] = ~r[c];
      if ($urandom_range(199, 0) == 0) begin
        #2 reset = 0;
        #1 zero_chk("rnd_rst");
        @(negedge clk);
        mchk();
        reset = 1;
      end
      cyc(r);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the pushbutton edge/press logic.
- Takes N raw, asynchronous, bouncy key inputs and synchronizes each into the clk domain.
- Filters each channel so a level change passes only after it has been stable for STABLE_CYCLES consecutive cycles.
- Drives one clean level per key, which feeds the single-bit button input (w) of the downstream press logic directly.

Parameters:
- N, 4, number of independent key channels.
- SYNC_STAGES, 2, flops in each synchronizer chain; legal range ≥2.
- STABLE_CYCLES, 4, consecutive cycles of mismatch needed before clean follows. Legal range ≥2. Default is sized for simulation; board build overrides to 500000.
- INVERT, 0, when 1, raw is inverted before synchronizing (active-low board keys).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset: 0 resets immediately, 1 runs.
- raw  input  N  unsynchronized key levels.
- clean  output  N  debounced level per channel, registered.
- busy  output  N  per channel, 1 while a candidate change is being counted.

Behaviour:
- Channels are fully independent. No cross-channel interaction; simultaneous changes on several channels are each handled on their own timeline.
- Reset (reset==0, asynchronous):
  - All synchronizer flops, counters, state, clean and busy go to 0 at once, with no clock edge needed.
  - This applies even when INVERT=1; the post-inversion idle level is 0.
- Synchronizer:
  - s = last stage of a SYNC_STAGES-deep flop chain clocked by clk, sampling (raw XOR INVERT).
- Per-channel FSM, states STABLE and COUNTING; counter cnt is $clog2(STABLE_CYCLES) bits.
  - STABLE, s==clean: stay, cnt=0.
  - STABLE, s!=clean: go to COUNTING, cnt<=1.
  - COUNTING, s==clean (glitch ended): go to STABLE, cnt<=0, clean unchanged.
  - COUNTING, s!=clean, cnt<STABLE_CYCLES-1: cnt<=cnt+1.
  - COUNTING, s!=clean, cnt==STABLE_CYCLES-1: clean<=s, cnt<=0, go to STABLE.
- busy = (state==COUNTING), registered via state.
- Latency:
  - Raw changes before edge 1 and is then held. clean changes on edge SYNC_STAGES+STABLE_CYCLES (default: edge 6).
  - busy is high after edges SYNC_STAGES+1 through SYNC_STAGES+STABLE_CYCLES-1 (default: after edges 3..5), and low after the edge that updates clean.
- Rejected pulses:
  - Any pulse at s shorter than STABLE_CYCLES cycles never reaches clean.
  - Each bounce back to the clean level restarts the count from zero.
- Counter never wraps: it is cleared on either exit from COUNTING.
- Reset mid-count discards the partial count.
  - If raw is held active through release, clean rises SYNC_STAGES+STABLE_CYCLES edges after the first edge following release.
- No combinational path from raw to any output.

Decomposition:
- Shared package button_pkg holds:
  - typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;
  - default constants DB_SYNC_STAGES=2 and DB_STABLE_CYCLES=4, reused by the downstream press logic and its benches.
- One sub-module, debounce_channel: a single-bit synchronizer + FSM + counter, with the same parameters minus N.
- Top level generates N instances and applies INVERT at its input.

Test Plan (defaults unless stated):
1. Hold reset=0 with raw=4'hF mid-cycle → clean=0 and busy=0 immediately, and they stay 0 across edges while reset=0.
2. Release reset. Set raw[0]=1 before edge 1 and hold → busy[0]=1 after edges 3..5; clean[0]=1 after edge 6; clean[3:1] stay 0.
3. raw[1]=1 for 2 cycles, then 0 → clean[1] stays 0 throughout; busy[1] pulses 2 cycles, then returns to 0.
4. raw[2] toggles 1,0,1,0,1 on successive cycles, then holds 1 → clean[2] rises exactly 6 edges after the final 0→1 transition; no earlier change.
5. With clean[0]=1, drop raw[0] and raise raw[3] on the same cycle → clean[0] falls and clean[3] rises on the same edge (edge 6).
6. raw[1] held 1; assert reset after edge 4 (mid-count) → clean and busy clear asynchronously. Release: clean[1] rises 6 edges later.
7. Rerun scenario 2 with INVERT=1, driving raw[0]=0 as the press → identical clean/busy timing.
